arm_exec_monitor: RTL and testbench
===================================

ARM_EXEC_MONITOR -- requirements
Module: arm_exec_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of every event counter.
REQ-002 Parameter JUMP_LIMIT, default 3: jump count that ends a run (1..2^CNT_W-1).
REQ-003 Parameter TIMEOUT_CYC, default 100: RUN cycles before timeout (>=1).
REQ-004 Parameter PC_W, default 32: program-counter width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clear  in  1  synchronous restart: same effect as reset, lower priority than reset.
REQ-008 pc  in  PC_W  current fetch PC of core.
REQ-009 instr  in  32  current instruction.
REQ-010 reg_write  in  1  core register write strobe.
REQ-011 mem_write  in  1  core data-memory write strobe.
REQ-012 arith_cnt, store_cnt, jump_cnt  out  CNT_W each  event counts.
REQ-013 cycle_cnt  out  CNT_W  RUN cycles elapsed.
REQ-014 jump_from, jump_to  out  PC_W each  PCs of most recent jump.
REQ-015 state  out  2  current FSM state (package enum).
REQ-016 done, timeout  out  1 each  terminal status flags.

Function
REQ-017 FSM states IDLE, RUN, DONE, TOUT; IDLE->RUN on first non-reset cycle; DONE and TOUT hold until reset/clear.
REQ-018 Events sampled only in RUN; outputs registered, visible one cycle after sampling edge.
REQ-019 Arithmetic event: reg_write=1, instr[27:26]=00, instr[24:21] = 0010 (SUB) or 0100 (ADD); other opcodes (MOV etc.) not counted.
REQ-020 Store event: mem_write=1 in a sampled cycle; one count per cycle.
REQ-021 Internal prev_pc with prev_valid flag; prev_valid set after first RUN sample.
REQ-022 Jump event: prev_valid=1, pc != prev_pc+4 (modulo 2^PC_W), pc != 0; jump_from<=prev_pc, jump_to<=pc.
REQ-023 prev_pc updated every RUN cycle regardless of event.
REQ-024 Counters saturate at all-ones; no wrap.
REQ-025 Arithmetic, store, jump events in the same cycle all counted.
REQ-026 cycle_cnt increments every RUN cycle.
REQ-027 jump_cnt reaching JUMP_LIMIT: next state DONE, done=1, all counters frozen.
REQ-028 cycle_cnt reaching TIMEOUT_CYC without limit jump: next state TOUT, timeout=1, counters frozen.
REQ-029 Limit jump and timeout in the same cycle: DONE wins; timeout stays 0.
REQ-030 done and timeout never both 1.
REQ-031 clear in any state, including mid-RUN: next cycle IDLE, counters zero, prev_valid=0.

Reset
REQ-032 On reset: state=IDLE, all counters 0, jump_from=jump_to=0, prev_pc=0, prev_valid=0, done=0, timeout=0.
REQ-033 Reset overrides clear and any same-cycle event.

Structure
REQ-034 Package arm_mon_pkg holds state enum, opcode constants OP_SUB=0010, OP_ADD=0100, DP class 00.
REQ-035 Sub-module sat_counter (parameter W; inputs clk, reset, clr, inc; output count) instanced four times.
REQ-036 No combinational path from inputs to outputs.

Verification
REQ-037 Straight-line ADD, SUB, MOV with reg_write, PC 0,4,8 -> arith_cnt=2, jump_cnt=0, state RUN.
REQ-038 PC 0,4,8,0x20,0x24,0x04,0x08,0x30 -> jump_cnt=3, jump_from=0x08, jump_to=0x30, done=1, counts frozen.
REQ-039 TIMEOUT_CYC=10, PC increments by 4, no jumps -> timeout=1 after cycle_cnt=10, done=0.
REQ-040 CNT_W=4, mem_write high 20 RUN cycles -> store_cnt=15 held.
REQ-041 clear asserted mid-RUN with arith_cnt=5 -> next cycle IDLE, all counters 0; counting resumes.
REQ-042 TIMEOUT_CYC=6, third jump on 6th RUN cycle -> done=1, timeout=0.

Source files
------------

// File: rtl/arm_mon_pkg.sv
// Shared types and decode constants for the ARM execution monitor.
package arm_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_e;

  // Data-processing instruction class (instr[27:26]) and opcodes (instr[24:21]).
  localparam logic [1:0] DP_CLASS = 2'b00;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;

  // True for data-processing ADD/SUB; MOV and every other opcode are ignored.
  function automatic logic is_arith_op(input logic [1:0] op_class,
                                       input logic [3:0] opcode);
    return (op_class == DP_CLASS) && ((opcode == OP_SUB) || (opcode == OP_ADD));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: restart wins, otherwise step until all-ones and stick there.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/arm_exec_monitor.sv
// Watches a core's fetch/write stream, counting ADD/SUB, stores and taken
// jumps until a jump limit (DONE) or a cycle budget (TOUT) ends the run.
module arm_exec_monitor
  import arm_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int JUMP_LIMIT  = 3,
  parameter int TIMEOUT_CYC = 100,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             reg_write,
  input  logic             mem_write,
  output logic [CNT_W-1:0] arith_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  jump_from,
  output logic [PC_W-1:0]  jump_to,
  output logic [1:0]       state,
  output logic             done,
  output logic             timeout
);

  // Count value that, once incremented, lands on the limit.
  localparam logic [CNT_W-1:0] JUMP_LAST = CNT_W'(JUMP_LIMIT - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  // A budget beyond the counter range can never be reached (counter sticks).
  localparam longint unsigned  CNT_MAX        = (64'(1) << CNT_W) - 64'(1);
  localparam bit               TOUT_REACHABLE = (64'(TIMEOUT_CYC) <= CNT_MAX);

  state_e          state_q, state_d;
  logic [PC_W-1:0] prev_pc_q, prev_pc_d;
  logic            prev_valid_q, prev_valid_d;
  logic [PC_W-1:0] jump_from_q, jump_from_d;
  logic [PC_W-1:0] jump_to_q, jump_to_d;

  logic run;
  logic arith_ev;
  logic store_ev;
  logic jump_ev;
  logic limit_hit;
  logic tout_hit;

  // Only the class and opcode fields of the instruction matter here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:28], instr[25], instr[20:0]};

  // Event decode; everything is qualified by RUN so other states sample nothing.
  always_comb begin
    run       = (state_q == RUN);
    arith_ev  = run && reg_write && is_arith_op(instr[27:26], instr[24:21]);
    store_ev  = run && mem_write;
    jump_ev   = run && prev_valid_q && (pc != prev_pc_q + PC_W'(4)) && (pc != '0);
    limit_hit = jump_ev && (jump_cnt == JUMP_LAST);
    tout_hit  = run && TOUT_REACHABLE && (cycle_cnt == TOUT_LAST);
  end

  sat_counter #(.W(CNT_W)) u_arith_cnt (
    .clk(clk), .reset(reset), .clr(clear), .inc(arith_ev), .count(arith_cnt)
  );
  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk(clk), .reset(reset), .clr(clear), .inc(store_ev), .count(store_cnt)
  );
  sat_counter #(.W(CNT_W)) u_jump_cnt (
    .clk(clk), .reset(reset), .clr(clear), .inc(jump_ev), .count(jump_cnt)
  );
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .reset(reset), .clr(clear), .inc(run), .count(cycle_cnt)
  );

  // Next state, PC history and last-jump capture; clear restarts like reset.
  always_comb begin
    state_d      = state_q;
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    jump_from_d  = jump_from_q;
    jump_to_d    = jump_to_q;
    if (clear) begin
      state_d      = IDLE;
      prev_pc_d    = '0;
      prev_valid_d = 1'b0;
      jump_from_d  = '0;
      jump_to_d    = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          prev_pc_d    = pc;
          prev_valid_d = 1'b1;
          if (jump_ev) begin
            jump_from_d = prev_pc_q;
            jump_to_d   = pc;
          end
          // A limit jump beats a timeout landing on the same cycle.
          if (limit_hit) begin
            state_d = DONE;
          end else if (tout_hit) begin
            state_d = TOUT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State registers; reset overrides clear and any same-cycle event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      jump_from_q  <= '0;
      jump_to_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      jump_from_q  <= jump_from_d;
      jump_to_q    <= jump_to_d;
    end
  end

  assign jump_from = jump_from_q;
  assign jump_to   = jump_to_q;
  assign state     = state_q;
  assign done      = (state_q == DONE);
  assign timeout   = (state_q == TOUT);

endmodule

// File: tb/tb_arm_exec_monitor.sv
// Scoreboard bench: a cycle model predicts the default monitor, while
// parameter variants are checked against hand-derived end values.
module tb_arm_exec_monitor;
  import arm_mon_pkg::*;

  localparam logic [31:0] I_ADD = 32'hE0810002;  // class 00, opcode 0100
  localparam logic [31:0] I_SUB = 32'hE0410002;  // class 00, opcode 0010
  localparam logic [31:0] I_MOV = 32'hE1A00001;  // class 00, opcode 1101
  localparam logic [31:0] I_LDS = 32'hE4810000;  // class 01, opcode field 0100

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, clear = 1'b0;
  logic [31:0] pc = '0, instr = '0;
  logic        reg_write = 1'b0, mem_write = 1'b0;

  // Default instance
  logic [15:0] a_arith, a_store, a_jump, a_cycle;
  logic [31:0] a_jf, a_jt;
  logic [1:0]  a_state;
  logic        a_done, a_tout;

  arm_exec_monitor dut_a (
    .clk(clk), .reset(reset), .clear(clear), .pc(pc), .instr(instr),
    .reg_write(reg_write), .mem_write(mem_write),
    .arith_cnt(a_arith), .store_cnt(a_store), .jump_cnt(a_jump), .cycle_cnt(a_cycle),
    .jump_from(a_jf), .jump_to(a_jt), .state(a_state), .done(a_done), .timeout(a_tout)
  );

  // TIMEOUT_CYC = 10
  logic [15:0] t10_cycle, t10_unused_arith, t10_unused_store, t10_unused_jump;
  logic [31:0] t10_unused_jf, t10_unused_jt;
  logic [1:0]  t10_state;
  logic        t10_done, t10_tout;

  arm_exec_monitor #(.TIMEOUT_CYC(10)) dut_t10 (
    .clk(clk), .reset(reset), .clear(clear), .pc(pc), .instr(instr),
    .reg_write(reg_write), .mem_write(mem_write),
    .arith_cnt(t10_unused_arith), .store_cnt(t10_unused_store), .jump_cnt(t10_unused_jump),
    .cycle_cnt(t10_cycle), .jump_from(t10_unused_jf), .jump_to(t10_unused_jt),
    .state(t10_state), .done(t10_done), .timeout(t10_tout)
  );

  // CNT_W = 4
  logic [3:0]  c4_store, c4_unused_arith, c4_unused_jump, c4_unused_cycle;
  logic [31:0] c4_unused_jf, c4_unused_jt;
  logic [1:0]  c4_state;
  logic        c4_unused_done, c4_unused_tout;

  arm_exec_monitor #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .clear(clear), .pc(pc), .instr(instr),
    .reg_write(reg_write), .mem_write(mem_write),
    .arith_cnt(c4_unused_arith), .store_cnt(c4_store), .jump_cnt(c4_unused_jump),
    .cycle_cnt(c4_unused_cycle), .jump_from(c4_unused_jf), .jump_to(c4_unused_jt),
    .state(c4_state), .done(c4_unused_done), .timeout(c4_unused_tout)
  );

  // TIMEOUT_CYC = 6
  logic [15:0] t6_jump, t6_cycle, t6_unused_arith, t6_unused_store;
  logic [31:0] t6_unused_jf, t6_unused_jt;
  logic [1:0]  t6_state;
  logic        t6_done, t6_tout;

  arm_exec_monitor #(.TIMEOUT_CYC(6)) dut_t6 (
    .clk(clk), .reset(reset), .clear(clear), .pc(pc), .instr(instr),
    .reg_write(reg_write), .mem_write(mem_write),
    .arith_cnt(t6_unused_arith), .store_cnt(t6_unused_store), .jump_cnt(t6_jump),
    .cycle_cnt(t6_cycle), .jump_from(t6_unused_jf), .jump_to(t6_unused_jt),
    .state(t6_state), .done(t6_done), .timeout(t6_tout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs of the default instance after one clock edge.
  typedef struct {
    logic [1:0]  state;
    int unsigned arith, store, jump, cycle;
    logic [31:0] jf, jt;
    logic        done, tout;
  } exp_t;

  exp_t        sb_q[$];
  int          step_no = 0;

  state_e      m_state = IDLE;
  int unsigned m_arith = 0, m_store = 0, m_jump = 0, m_cycle = 0;
  logic [31:0] m_prev = '0, m_jf = '0, m_jt = '0;
  bit          m_pv = 1'b0;

  function automatic int unsigned bump(input int unsigned v);
    return (v < 32'd65535) ? v + 1 : v;
  endfunction

  task automatic model(input logic r, input logic c, input logic [31:0] p,
                       input logic [31:0] ins, input logic rw, input logic mw);
    bit is_arith, is_jump;
    if (r || c) begin
      m_state = IDLE; m_arith = 0; m_store = 0; m_jump = 0; m_cycle = 0;
      m_prev = '0; m_jf = '0; m_jt = '0; m_pv = 1'b0;
    end else if (m_state == IDLE) begin
      m_state = RUN;
    end else if (m_state == RUN) begin
      is_arith = rw && (ins[27:26] == 2'b00) &&
                 ((ins[24:21] == 4'b0100) || (ins[24:21] == 4'b0010));
      is_jump  = m_pv && (p != m_prev + 32'd4) && (p != 32'd0);
      m_cycle  = bump(m_cycle);
      if (is_arith) m_arith = bump(m_arith);
      if (mw)       m_store = bump(m_store);
      if (is_jump) begin
        m_jump = bump(m_jump);
        m_jf   = m_prev;
        m_jt   = p;
      end
      m_prev = p;
      m_pv   = 1'b1;
      if (is_jump && m_jump == 3)  m_state = DONE;
      else if (m_cycle == 100)     m_state = TOUT;
    end
  endtask

  // Drive one cycle of stimulus, push the prediction, compare after the edge.
  task automatic step(input logic r, input logic c, input logic [31:0] p,
                      input logic [31:0] ins, input logic rw, input logic mw);
    exp_t e;
    @(negedge clk);
    reset = r; clear = c; pc = p; instr = ins; reg_write = rw; mem_write = mw;
    model(r, c, p, ins, rw, mw);
    e.state = m_state; e.arith = m_arith; e.store = m_store; e.jump = m_jump;
    e.cycle = m_cycle; e.jf = m_jf; e.jt = m_jt;
    e.done = (m_state == DONE); e.tout = (m_state == TOUT);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    e = sb_q.pop_front();
    check($sformatf("s%0d.state", step_no), 64'(a_state), 64'(e.state));
    check($sformatf("s%0d.arith", step_no), 64'(a_arith), 64'(e.arith));
    check($sformatf("s%0d.store", step_no), 64'(a_store), 64'(e.store));
    check($sformatf("s%0d.jump",  step_no), 64'(a_jump),  64'(e.jump));
    check($sformatf("s%0d.cycle", step_no), 64'(a_cycle), 64'(e.cycle));
    check($sformatf("s%0d.jfrom", step_no), 64'(a_jf),    64'(e.jf));
    check($sformatf("s%0d.jto",   step_no), 64'(a_jt),    64'(e.jt));
    check($sformatf("s%0d.done",  step_no), 64'(a_done),  64'(e.done));
    check($sformatf("s%0d.tout",  step_no), 64'(a_tout),  64'(e.tout));
    check($sformatf("s%0d.excl",  step_no), 64'(a_done & a_tout), 64'(0));
  endtask

  // Reset for one cycle, then spend the IDLE->RUN cycle.
  task automatic restart();
    step(1'b1, 1'b0, 32'h0, I_MOV, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h1000, I_ADD, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] pcs[8];

    // Reset values, then straight-line ADD, SUB, MOV
    step(1'b1, 1'b0, 32'h0, I_MOV, 1'b0, 1'b0);
    check("rst_state", 64'(a_state), 64'(IDLE));
    check("rst_arith", 64'(a_arith), 64'(0));
    step(1'b0, 1'b0, 32'h1000, I_ADD, 1'b1, 1'b1);
    check("idle_to_run_no_sample", 64'(a_arith), 64'(0));
    step(1'b0, 1'b0, 32'h0, I_ADD, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h4, I_SUB, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h8, I_MOV, 1'b1, 1'b0);
    check("line_arith", 64'(a_arith), 64'(2));
    check("line_jump",  64'(a_jump),  64'(0));
    check("line_state", 64'(a_state), 64'(RUN));
    step(1'b0, 1'b0, 32'hC,  I_ADD, 1'b0, 1'b0);  // no reg_write
    step(1'b0, 1'b0, 32'h10, I_LDS, 1'b1, 1'b0);  // not data-processing
    check("non_arith", 64'(a_arith), 64'(2));

    // Three jumps end the run; counters freeze afterwards
    restart();
    pcs = '{32'h0, 32'h4, 32'h8, 32'h20, 32'h24, 32'h04, 32'h08, 32'h30};
    foreach (pcs[i]) step(1'b0, 1'b0, pcs[i], I_MOV, 1'b0, 1'b0);
    check("lim_jump",  64'(a_jump),  64'(3));
    check("lim_jfrom", 64'(a_jf),    64'(32'h08));
    check("lim_jto",   64'(a_jt),    64'(32'h30));
    check("lim_done",  64'(a_done),  64'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h100 * (i + 1), I_ADD, 1'b1, 1'b1);
    check("frz_cycle", 64'(a_cycle), 64'(8));
    check("frz_arith", 64'(a_arith), 64'(0));
    check("frz_store", 64'(a_store), 64'(0));
    check("frz_state", 64'(a_state), 64'(DONE));

    // PC wrap is sequential, pc==0 never a jump, coincident events all count
    restart();
    step(1'b0, 1'b0, 32'hFFFF_FFF8, I_MOV, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'hFFFF_FFFC, I_MOV, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0,         I_MOV, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h4,         I_MOV, 1'b0, 1'b0);
    check("wrap_nojump", 64'(a_jump), 64'(0));
    step(1'b0, 1'b0, 32'h40, I_ADD, 1'b1, 1'b1);
    check("all3_arith", 64'(a_arith), 64'(1));
    check("all3_store", 64'(a_store), 64'(1));
    check("all3_jump",  64'(a_jump),  64'(1));
    step(1'b0, 1'b0, 32'h0, I_MOV, 1'b0, 1'b0);
    check("pc0_nojump", 64'(a_jump), 64'(1));

    // clear mid-RUN, then counting resumes
    restart();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'(4 * i), I_ADD, 1'b1, 1'b0);
    check("pre_clr_arith", 64'(a_arith), 64'(5));
    step(1'b0, 1'b1, 32'h14, I_ADD, 1'b1, 1'b1);
    check("clr_state", 64'(a_state), 64'(IDLE));
    check("clr_arith", 64'(a_arith), 64'(0));
    check("clr_cycle", 64'(a_cycle), 64'(0));
    step(1'b0, 1'b0, 32'h18, I_ADD, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h200, I_ADD, 1'b1, 1'b0);
    check("resume_arith", 64'(a_arith), 64'(1));
    check("resume_nojump", 64'(a_jump), 64'(0));
    step(1'b1, 1'b1, 32'h300, I_ADD, 1'b1, 1'b1);
    check("rst_over_clr", 64'(a_state), 64'(IDLE));

    // Timeout after 10 RUN cycles
    restart();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'(4 * i), I_MOV, 1'b0, 1'b0);
      if (i == 8) check("t10_before", 64'(t10_tout), 64'(0));
    end
    check("t10_tout",  64'(t10_tout),  64'(1));
    check("t10_cycle", 64'(t10_cycle), 64'(10));
    check("t10_done",  64'(t10_done),  64'(0));
    check("t10_state", 64'(t10_state), 64'(TOUT));
    step(1'b0, 1'b0, 32'h28, I_MOV, 1'b0, 1'b0);
    check("t10_hold", 64'(t10_cycle), 64'(10));

    // 4-bit counters saturate
    restart();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'(4 * i), I_MOV, 1'b0, 1'b1);
    check("c4_store", 64'(c4_store), 64'(15));
    check("c4_state", 64'(c4_state), 64'(RUN));
    for (int i = 20; i < 22; i++) step(1'b0, 1'b0, 32'(4 * i), I_MOV, 1'b0, 1'b1);
    check("c4_held", 64'(c4_store), 64'(15));

    // Limit jump and timeout on the same cycle: DONE wins
    restart();
    pcs = '{32'h0, 32'h10, 32'h14, 32'h40, 32'h44, 32'h80, 32'h84, 32'h88};
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, pcs[i], I_MOV, 1'b0, 1'b0);
    check("t6_done",  64'(t6_done),  64'(1));
    check("t6_tout",  64'(t6_tout),  64'(0));
    check("t6_state", 64'(t6_state), 64'(DONE));
    check("t6_jump",  64'(t6_jump),  64'(3));
    check("t6_cycle", 64'(t6_cycle), 64'(6));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
